// File: rtl/shiftright_seq.sv
// shiftright_seq: multi-cycle 32-bit logical/arithmetic right shifter built on one shared 16x16 multiplier
module shiftright_seq #(
  parameter bit EARLY_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        arith,
  output logic [31:0] c,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, FIN} state_t;
  state_t state, state_nx;
  logic [31:0] a_r, x, m, prod;
  logic [4:0] n;
  logic neg, accept, zero_skip;
  logic [15:0] xs, ms;
  logic [5:0] sh;
  logic [63:0] acc, term, sum;
  assign accept = state == IDLE && start;
  assign zero_skip = EARLY_ZERO && b[4:0] == 5'd0;
  // Sign-filling shift is done as ~((~a) >> n), so the multiplier only ever sees x.
  assign x = neg ? ~a_r : a_r;
  assign m = n == 5'd0 ? 32'd0 : 32'd1 << (6'd32 - {1'b0, n});
  assign xs = (state == P0 || state == P1) ? x[15:0] : x[31:16];
  assign ms = (state == P0 || state == P2) ? m[15:0] : m[31:16];
  assign prod = {16'd0, xs} * {16'd0, ms};
  assign sh = state == P0 ? 6'd0 : state == P3 ? 6'd32 : 6'd16;
  assign term = {32'd0, prod} << sh;
  assign sum = acc + term;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE: state_nx = !start ? IDLE : zero_skip ? FIN : P0;
      P0: state_nx = P1;
      P1: state_nx = P2;
      P2: state_nx = P3;
      P3: state_nx = FIN;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == FIN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r <= '0;
      n <= '0;
      neg <= 1'b0;
      acc <= '0;
      c <= '0;
    end else begin
      if (accept) begin
        a_r <= a;
        n <= b[4:0];
        neg <= arith & a[31];
        acc <= '0;
        if (zero_skip) c <= a;
      end else if (state == P0 || state == P1 || state == P2 || state == P3) acc <= sum;
      if (state == P3) c <= n == 5'd0 ? a_r : neg ? ~sum[63:32] : sum[63:32];
    end
  end
endmodule
